mmio_cmd_initiator: RTL and testbench
=====================================

# mmio_cmd_initiator

Bus-master front end for the FPro MMIO bus: accepts burst read/write commands on a valid/ready command port and issues single-cycle `mmio_cs`/`mmio_wr`/`mmio_rd` strobes toward the MMIO controller.
- Read data is returned on a valid/ready response port.
- Write data arrives on a separate valid/ready data port.
- Sits between a host-side agent (UART debug bridge, DMA sequencer) and the MMIO subsystem, in place of the processor bridge or alongside it behind an arbiter.

## Interface
Parameters:
- `ADDR_W`, 21: MMIO word-address width; slot is `addr[10:5]`, register is `addr[4:0]`.
- `LEN_W`, 8: burst-length field width; beats = `cmd_len`+1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when both are high.
- `cmd_wr`  in  1  1 = write burst, 0 = read burst.
- `cmd_inc`  in  1  1 = increment address each beat, 0 = fixed address (FIFO-style register).
- `cmd_addr`  in  ADDR_W  start word address.
- `cmd_len`  in  LEN_W  beats minus one.
- `wdat_valid`  in  1  write data offered.
- `wdat_ready`  out  1  write data accepted when both are high.
- `wdat_data`  in  32  write data word.
- `rsp_valid`  out  1  response word valid.
- `rsp_ready`  in  1  response consumed when both are high.
- `rsp_data`  out  32  read data, or write count with `MMIO_INIT_WRACK_EN`.
- `rsp_last`  out  1  final response of a burst.
- `busy`  out  1  high whenever state is not IDLE.
- `mmio_cs`, `mmio_wr`, `mmio_rd`  out  1  FPro bus strobes.
- `mmio_addr`  out  ADDR_W  bus word address.
- `mmio_wr_data`  out  32  bus write data.
- `mmio_rd_data`  in  32  bus read data; valid in the strobe cycle.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch wr, inc, addr, and beat counter = `cmd_len`. Go to WR_WAIT if write, RD_STB if read.
  - WR_WAIT: `wdat_ready`=1. On `wdat_valid`, latch data and go to WR_STB.
  - WR_STB: assert `mmio_cs`+`mmio_wr` for exactly one cycle.
    - Counter==0: go to WR_ACK if `MMIO_INIT_WRACK_EN` is defined, else IDLE.
    - Otherwise: decrement the counter, advance the address if inc, and go to WR_WAIT.
  - RD_STB: assert `mmio_cs`+`mmio_rd` for one cycle, capture `mmio_rd_data` into the response register, set `rsp_last` = (counter==0), go to RD_HOLD.
  - RD_HOLD: `rsp_valid`=1 and the response register is held stable. On `rsp_ready`:
    - Counter==0: go to IDLE.
    - Otherwise: decrement the counter, advance the address if inc, and go to RD_STB.
  - WR_ACK: `rsp_valid`=1, `rsp_data` = beats written, `rsp_last`=1. On `rsp_ready`, go to IDLE.
- Exactly one bus strobe per beat. No strobe is issued while a read response is unconsumed, so there is never a read side effect without a delivered word.
- Address arithmetic is modulo 2^ADDR_W: 0x1FFFFF+1 wraps to 0x000000, with no carry into any other field.
- `cmd_len`=0 gives 1 beat; `cmd_len`=0xFF gives 256 beats. The write count is 9 bits, zero-extended to 32.
- `wdat_valid` outside WR_WAIT is ignored and not consumed.
- `cmd_valid` outside IDLE is ignored.

## Timing
- All bus outputs and `rsp_*` are registered.
- `cmd_ready` and `wdat_ready` are decoded from state only; no combinational path from inputs.
- Reset values:
  - state IDLE, `mmio_cs`/`mmio_wr`/`mmio_rd`=0.
  - `mmio_addr`=0, `mmio_wr_data`=0.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `busy`=0.
  - `cmd_ready`=0 and `wdat_ready`=0 while `reset` is high.
- Read latency: command accepted at cycle T; strobe at T+1; `rsp_valid` at T+2. With `rsp_ready` held high, beats repeat every 2 cycles.
- Write latency: data accepted at cycle t; strobe at t+1. Minimum 2 cycles per beat.
- Reset mid-burst: the next cycle is IDLE and the remaining beats are dropped.
  - A pending response is discarded; `rsp_valid`=0.
  - No strobe is asserted in any cycle in which `reset` is sampled high.
- `rsp_ready` high while `rsp_valid` is low has no effect.

## Configuration
- Macro: `MMIO_INIT_WRACK_EN`.
- Defined: each completed write burst produces one response in WR_ACK, with `rsp_data` = beat count and `rsp_last`=1.
- Undefined:
  - WR_ACK does not exist.
  - Write bursts return to IDLE directly after the last strobe.
  - `rsp_valid` is asserted only for reads.

## Test plan
- Single read: cmd rd, addr 0x0060 (slot 3 reg 0), len 0, `mmio_rd_data`=0x000000A5 -> one `mmio_rd` strobe at T+1 with addr 0x0060; `rsp_data`=0xA5 and `rsp_last`=1 at T+2.
- Incrementing write burst: addr 0x0040, len 3, inc=1, data 1..4 -> four `mmio_wr` strobes at addresses 0x40..0x43 carrying data 1..4; with `MMIO_INIT_WRACK_EN` defined, one response with `rsp_data`=4.
- Fixed-address read backpressure: addr 0x0021, len 2, inc=0, `rsp_ready` low for 5 cycles after each `rsp_valid` -> exactly 3 strobes, all at 0x0021; no second strobe before the first response is consumed; `rsp_last` only on the third response.
- Address wrap: read at 0x1FFFFF, len 1, inc=1 -> strobes at 0x1FFFFF then 0x000000.
- Write data stall: `wdat_valid` withheld 10 cycles -> no strobe and `busy`=1 throughout; strobe exactly one cycle after the data is accepted.
- Reset during a len=7 read after beat 2 -> no further strobes, `rsp_valid`=0, `cmd_ready`=1 on the first cycle after `reset` deasserts, and a new command is accepted normally.

Source files
------------

// File: rtl/mmio_cmd_initiator_if.sv
// mmio_cmd_initiator_if: command, write-data and response handshakes plus
// the FPro MMIO bus strobes, bundled for the burst initiator.
// master = the initiator itself, slave = the host agent / MMIO side.
interface mmio_cmd_initiator_if #(
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic              cmd_inc;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LEN_W-1:0]  cmd_len;

   logic              wdat_valid;
   logic              wdat_ready;
   logic [31:0]       wdat_data;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_data;
   logic              rsp_last;

   logic              busy;

   logic              mmio_cs;
   logic              mmio_wr;
   logic              mmio_rd;
   logic [ADDR_W-1:0] mmio_addr;
   logic [31:0]       mmio_wr_data;
   logic [31:0]       mmio_rd_data;

   modport master (
      input  cmd_valid, cmd_wr, cmd_inc, cmd_addr, cmd_len,
      output cmd_ready,
      input  wdat_valid, wdat_data,
      output wdat_ready,
      output rsp_valid, rsp_data, rsp_last,
      input  rsp_ready,
      output busy,
      output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
      input  mmio_rd_data
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_inc, cmd_addr, cmd_len,
      input  cmd_ready,
      output wdat_valid, wdat_data,
      input  wdat_ready,
      input  rsp_valid, rsp_data, rsp_last,
      output rsp_ready,
      input  busy,
      input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
      output mmio_rd_data
   );
endinterface

// File: rtl/mmio_cmd_initiator.sv
// mmio_cmd_initiator: burst read/write front end for the FPro MMIO bus.
// One command becomes cmd_len+1 single-cycle strobes; reads are returned one
// word at a time and the next read strobe waits until the previous word is
// consumed, so no read side effect is ever lost.
// Optional feature macro: MMIO_INIT_WRACK_EN (one count response per write burst).
module mmio_cmd_initiator #(
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   mmio_cmd_initiator_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      WR_WAIT,
      WR_STB,
      RD_STB,
      RD_HOLD
`ifdef MMIO_INIT_WRACK_EN
      , WR_ACK
`endif
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] cnt;        // beats remaining after the current one
   logic             inc_q;
   logic             last_beat;
   logic             cmd_acc;
   logic             advance;
`ifdef MMIO_INIT_WRACK_EN
   logic [LEN_W-1:0] len_q;
`endif

   assign last_beat = (cnt == '0);
   assign cmd_acc   = (state == IDLE) && bus.cmd_valid;
   // Move to the next beat once a write strobe is done or a read word is taken.
   assign advance   = !last_beat &&
                      ((state == WR_STB) || ((state == RD_HOLD) && bus.rsp_ready));

   // State register; reset drops any burst in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.cmd_valid) state_nxt = bus.cmd_wr ? WR_WAIT : RD_STB;
         WR_WAIT: if (bus.wdat_valid) state_nxt = WR_STB;
         WR_STB: begin
            if (!last_beat) state_nxt = WR_WAIT;
`ifdef MMIO_INIT_WRACK_EN
            else            state_nxt = WR_ACK;
`else
            else            state_nxt = IDLE;
`endif
         end
         RD_STB:  state_nxt = RD_HOLD;
         RD_HOLD: if (bus.rsp_ready) state_nxt = last_beat ? IDLE : RD_STB;
`ifdef MMIO_INIT_WRACK_EN
         WR_ACK:  if (bus.rsp_ready) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Ready/busy decode from state; readies are forced low while reset is held.
   always_comb begin
      bus.cmd_ready  = (state == IDLE) && !reset;
      bus.wdat_ready = (state == WR_WAIT) && !reset;
      bus.busy       = (state != IDLE);
   end

   // Registered strobes: high exactly during the WR_STB / RD_STB cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mmio_cs <= 1'b0;
         bus.mmio_wr <= 1'b0;
         bus.mmio_rd <= 1'b0;
      end else begin
         bus.mmio_cs <= (state_nxt == WR_STB) || (state_nxt == RD_STB);
         bus.mmio_wr <= (state_nxt == WR_STB);
         bus.mmio_rd <= (state_nxt == RD_STB);
      end
   end

   // Command latch, beat counter and address stepping (wraps at 2^ADDR_W).
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.mmio_addr <= '0;
         cnt           <= '0;
         inc_q         <= 1'b0;
      end else if (cmd_acc) begin
         bus.mmio_addr <= bus.cmd_addr;
         cnt           <= bus.cmd_len;
         inc_q         <= bus.cmd_inc;
      end else if (advance) begin
         cnt <= cnt - LEN_W'(1);
         if (inc_q) bus.mmio_addr <= bus.mmio_addr + ADDR_W'(1);
      end
   end

   // Write data is taken only in WR_WAIT; offers in other states stay pending.
   always_ff @(posedge clk) begin
      if (reset)
         bus.mmio_wr_data <= '0;
      else if ((state == WR_WAIT) && bus.wdat_valid)
         bus.mmio_wr_data <= bus.wdat_data;
   end

`ifdef MMIO_INIT_WRACK_EN
   // Burst length kept for the write-count response.
   always_ff @(posedge clk) begin
      if (reset)        len_q <= '0;
      else if (cmd_acc) len_q <= bus.cmd_len;
   end
`endif

   // Response register: read word captured in the strobe cycle, held until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_last  <= 1'b0;
      end else begin
         if (state == RD_STB) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.mmio_rd_data;
            bus.rsp_last  <= last_beat;
         end else if ((state == RD_HOLD) && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
`ifdef MMIO_INIT_WRACK_EN
         if ((state == WR_STB) && last_beat) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= 32'(len_q) + 32'd1;
            bus.rsp_last  <= 1'b1;
         end else if ((state == WR_ACK) && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mmio_cmd_initiator.sv
// tb_mmio_cmd_initiator: table of directed bursts, randomized bursts and a
// mid-burst reset sequence. Expected strobe addresses, data and response
// words come from burst arithmetic on the command fields.
module tb_mmio_cmd_initiator;
   localparam int ADDR_W = 21;
   localparam int LEN_W  = 8;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   strobes = 0;

   always #5 clk = ~clk;

   mmio_cmd_initiator_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

   mmio_cmd_initiator #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Register file stand-in: every address reads back a distinct word.
   function automatic logic [31:0] rd_fn(input logic [20:0] a);
      if (a == 21'h000060) return 32'h0000_00A5;
      return {a[10:0], a} ^ 32'hC3A5_0F1E;
   endfunction

   assign bus.mmio_rd_data = rd_fn(bus.mmio_addr);

   // Count strobe cycles as seen on the bus.
   always @(posedge clk) if (bus.mmio_cs) strobes <= strobes + 1;

   typedef struct {
      bit          wr;
      bit          inc;
      logic [20:0] addr;
      logic [7:0]  len;
      int          stall;
      logic [31:0] dseed;
      logic [20:0] exp_last;
      int          exp_beats;
   } vec_t;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Issue one burst and check it cycle by cycle against the burst rules.
   task automatic run_cmd(input bit wr, input bit inc, input logic [20:0] addr,
                          input logic [7:0] len, input int stall, input logic [31:0] dseed,
                          output logic [20:0] last_a, output int nstb);
      int          n;
      int          s0;
      logic [20:0] a;
      logic [31:0] d;
      bus.cmd_wr    = wr;
      bus.cmd_inc   = inc;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         step();
         n++;
      end
      chk("cmd_ready", 32'(bus.cmd_ready), 32'd1);
      s0 = strobes;
      step();
      bus.cmd_valid = 1'b0;
      a = addr;
      for (int k = 0; k <= int'(len); k++) begin
         a = addr + (inc ? 21'(k) : 21'd0);
         if (wr) begin
            for (int j = 0; j < stall; j++) begin
               bus.rsp_ready = 1'b1;
               bus.cmd_valid = 1'b1;
               bus.cmd_wr    = 1'b0;
               bus.cmd_addr  = ~addr;
               chk("wstall_busy", 32'(bus.busy), 32'd1);
               chk("wstall_no_stb", 32'(bus.mmio_cs), 32'd0);
               chk("wstall_wdat_ready", 32'(bus.wdat_ready), 32'd1);
               step();
            end
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b0;
            d = dseed + 32'(k) + 32'd1;
            chk("wdat_ready", 32'(bus.wdat_ready), 32'd1);
            bus.wdat_valid = 1'b1;
            bus.wdat_data  = d;
            step();
            chk("wr_strobe", 32'({bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}), 32'b110);
            chk("wr_addr", 32'(bus.mmio_addr), 32'(a));
            chk("wr_data", bus.mmio_wr_data, d);
            // Offer during the strobe cycle must not be consumed.
            bus.wdat_data = 32'hDEAD_BEEF;
            step();
            bus.wdat_valid = 1'b0;
         end else begin
            chk("rd_strobe", 32'({bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}), 32'b101);
            chk("rd_addr", 32'(bus.mmio_addr), 32'(a));
            step();
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_data", bus.rsp_data, rd_fn(a));
            chk("rsp_last", 32'(bus.rsp_last), 32'(k == int'(len)));
            chk("rsp_no_stb", 32'(bus.mmio_cs), 32'd0);
            for (int j = 0; j < stall; j++) begin
               bus.rsp_ready = 1'b0;
               bus.cmd_valid = 1'b1;
               bus.cmd_wr    = 1'b1;
               bus.cmd_addr  = ~addr;
               step();
               chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
               chk("hold_data", bus.rsp_data, rd_fn(a));
               chk("hold_no_stb", 32'(bus.mmio_cs), 32'd0);
            end
            bus.cmd_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
         end
      end
`ifdef MMIO_INIT_WRACK_EN
      if (wr) begin
         chk("ack_valid", 32'(bus.rsp_valid), 32'd1);
         chk("ack_data", bus.rsp_data, 32'(len) + 32'd1);
         chk("ack_last", 32'(bus.rsp_last), 32'd1);
         bus.rsp_ready = 1'b1;
         step();
         bus.rsp_ready = 1'b0;
      end
`endif
      chk("end_busy", 32'(bus.busy), 32'd0);
      chk("end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("end_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      last_a = a;
      nstb   = strobes - s0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[7];
      logic [20:0] la;
      int          nb;
      int          s0;
      bit          r_wr;
      bit          r_inc;
      logic [20:0] r_addr;
      logic [20:0] r_exp;
      logic [7:0]  r_len;
      int          r_stall;

      //          wr    inc   addr        len     stall dseed     exp_last    beats
      tbl[0] = '{1'b0, 1'b0, 21'h000060, 8'd0,   0,    32'd0,    21'h000060, 1};
      tbl[1] = '{1'b1, 1'b1, 21'h000040, 8'd3,   0,    32'd0,    21'h000043, 4};
      tbl[2] = '{1'b0, 1'b0, 21'h000021, 8'd2,   5,    32'd0,    21'h000021, 3};
      tbl[3] = '{1'b0, 1'b1, 21'h1FFFFF, 8'd1,   0,    32'd0,    21'h000000, 2};
      tbl[4] = '{1'b1, 1'b1, 21'h000123, 8'd0,   10,   32'h100,  21'h000123, 1};
      tbl[5] = '{1'b1, 1'b1, 21'h1FFFF0, 8'd255, 0,    32'h5000, 21'h0000EF, 256};
      tbl[6] = '{1'b1, 1'b0, 21'h000007, 8'd4,   1,    32'h77,   21'h000007, 5};

      bus.cmd_valid  = 1'b0;
      bus.cmd_wr     = 1'b0;
      bus.cmd_inc    = 1'b0;
      bus.cmd_addr   = '0;
      bus.cmd_len    = '0;
      bus.wdat_valid = 1'b0;
      bus.wdat_data  = '0;
      bus.rsp_ready  = 1'b0;

      repeat (3) step();
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("rst_wdat_ready", 32'(bus.wdat_ready), 32'd0);
      chk("rst_strobes", 32'({bus.mmio_cs, bus.mmio_wr, bus.mmio_rd}), 32'd0);
      chk("rst_rsp", 32'({bus.rsp_valid, bus.rsp_last}), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_addr", 32'(bus.mmio_addr), 32'd0);
      chk("rst_wr_data", bus.mmio_wr_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      for (int i = 0; i < 7; i++) begin
         run_cmd(tbl[i].wr, tbl[i].inc, tbl[i].addr, tbl[i].len, tbl[i].stall,
                 tbl[i].dseed, la, nb);
         chk("tbl_last_addr", 32'(la), 32'(tbl[i].exp_last));
         chk("tbl_beats", 32'(nb), 32'(tbl[i].exp_beats));
      end

      for (int i = 0; i < 40; i++) begin
         r_wr    = 1'($urandom_range(0, 1));
         r_inc   = 1'($urandom_range(0, 1));
         r_addr  = 21'($urandom);
         if ($urandom_range(0, 3) == 0) r_addr = 21'h1FFFFF - 21'($urandom_range(0, 3));
         r_len   = 8'($urandom_range(0, 6));
         r_stall = int'($urandom_range(0, 3));
         run_cmd(r_wr, r_inc, r_addr, r_len, r_stall, $urandom, la, nb);
         r_exp = r_addr + (r_inc ? 21'(r_len) : 21'd0);
         chk("rnd_last_addr", 32'(la), 32'(r_exp));
         chk("rnd_beats", 32'(nb), 32'(r_len) + 32'd1);
      end

      // Reset while the second word of an 8-beat read is still pending.
      bus.cmd_wr    = 1'b0;
      bus.cmd_inc   = 1'b1;
      bus.cmd_addr  = 21'h000100;
      bus.cmd_len   = 8'd7;
      bus.cmd_valid = 1'b1;
      step();
      bus.cmd_valid = 1'b0;
      chk("mr_b0_stb", 32'(bus.mmio_rd), 32'd1);
      step();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("mr_b1_addr", 32'(bus.mmio_addr), 32'h101);
      step();
      chk("mr_b1_pending", 32'(bus.rsp_valid), 32'd1);
      s0 = strobes;
      reset = 1'b1;
      step();
      chk("mr_rst_no_stb", 32'(bus.mmio_cs), 32'd0);
      chk("mr_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mr_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("mr_rst_busy", 32'(bus.busy), 32'd0);
      step();
      reset = 1'b0;
      #1;
      chk("mr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (4) step();
      chk("mr_no_more_stb", 32'(strobes - s0), 32'd0);
      chk("mr_idle_rsp", 32'(bus.rsp_valid), 32'd0);
      run_cmd(1'b0, 1'b0, 21'h000060, 8'd0, 0, 32'd0, la, nb);
      chk("mr_new_beats", 32'(nb), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
